// File: rtl/and_lut_sweep_checker.sv
// Self-test sequencer for the AND gate/LUT comparison block: sweeps all 32 {sel,A,B} vectors,
// two cycles per vector (APPLY settle, CHECK sample). Optional macro SWEEP_STOP_ON_FAIL_EN halts on first failure.
module and_lut_sweep_checker #(
   parameter logic [1:0] MATCH_CODE = 2'b01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [1:0] op_a,
   output logic [1:0] op_b,
   output logic       sel,
   input  logic [1:0] res,
   input  logic [1:0] ok,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] err_cnt,
   output logic [4:0] fail_idx
);

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} state_t;

   state_t     state;
   logic [4:0] idx;
   logic [1:0] exp_res;
   logic       vec_fail;
   logic       stop_now;

   assign op_a = idx[3:2];
   assign op_b = idx[1:0];
   assign sel  = idx[4];

   assign exp_res  = op_a & op_b;
   assign vec_fail = (res != exp_res) || (ok != MATCH_CODE);
   assign pass     = done && (err_cnt == 6'd0);

`ifdef SWEEP_STOP_ON_FAIL_EN
   assign stop_now = vec_fail || (idx == 5'd31);
`else
   assign stop_now = (idx == 5'd31);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= 5'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_cnt  <= 6'd0;
         fail_idx <= 5'd0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               if (start) begin
                  idx      <= 5'd0;
                  err_cnt  <= 6'd0;
                  fail_idx <= 5'd0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  state    <= APPLY;
               end
            end
            APPLY: state <= CHECK;
            CHECK: begin
               if (vec_fail) begin
                  if (err_cnt != 6'd32)
                     err_cnt <= err_cnt + 6'd1;
                  if (err_cnt == 6'd0)
                     fail_idx <= idx;
               end
               // idx is left in place on exit so the last vector stays applied
               if (stop_now) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  idx   <= idx + 5'd1;
                  state <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_and_lut_sweep_checker.sv
// Bench for and_lut_sweep_checker: AND-block model with fault injection, scoreboard of
// expected vectors and sweep results popped by a negedge monitor.
module tb_and_lut_sweep_checker;

   localparam logic [1:0] MC = 2'b01;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] op_a, op_b, res, ok;
   logic       sel, busy, done, pass;
   logic [5:0] err_cnt;
   logic [4:0] fail_idx;

   logic [31:0] res_bad = 32'd0;
   logic        ok_bad = 1'b0;
   logic [4:0]  cur_vec;

   typedef struct {
      int err;
      int fidx;
      int pss;
      int cyc;
   } exp_t;

   int   vec_q[$];
   exp_t res_q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   and_lut_sweep_checker #(.MATCH_CODE(MC)) dut (
      .clk(clk), .rst(rst), .start(start),
      .op_a(op_a), .op_b(op_b), .sel(sel),
      .res(res), .ok(ok),
      .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_idx(fail_idx)
   );

   always #5 clk = ~clk;

   // AND gate/LUT block model with per-vector fault injection
   assign cur_vec = {sel, op_a, op_b};
   always_comb begin
      res = op_a & op_b;
      if (res_bad[cur_vec]) res = 2'b11;
      ok = ok_bad ? 2'b00 : MC;
   end

   task automatic check(input string name, input int act, input int req);
      total_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Monitor: compares applied vector on every CHECK cycle and results on each done rise
   logic prev_busy = 1'b0;
   logic prev_done = 1'b0;
   int   busy_cnt = 0;
   always @(negedge clk) begin
      if (busy && !prev_busy) busy_cnt = 1;
      else if (busy) busy_cnt++;
      if (busy && (busy_cnt % 2 == 0)) begin
         if (vec_q.size() == 0) begin
            total_cnt++;
            $display("FAIL vec_unexpected: got %0d, expected none", cur_vec);
         end else begin
            check("vec_order", int'(cur_vec), vec_q.pop_front());
         end
      end
      if (done && !prev_done) begin
         if (res_q.size() == 0) begin
            total_cnt++;
            $display("FAIL done_unexpected: got done, expected none");
         end else begin
            exp_t e;
            e = res_q.pop_front();
            check("err_cnt", int'(err_cnt), e.err);
            check("fail_idx", int'(fail_idx), e.fidx);
            check("pass", int'(pass), e.pss);
            check("sweep_cycles", busy_cnt, e.cyc);
         end
      end
      prev_busy = busy;
      prev_done = done;
   end

   task automatic push_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) vec_q.push_back(i);
   endtask

   task automatic push_res(input int err, input int fidx, input int pss, input int cyc);
      exp_t e;
      e.err = err; e.fidx = fidx; e.pss = pss; e.cyc = cyc;
      res_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!done && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", int'(done), 1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_pass"}, int'(pass), 0);
      check({tag, "_err_cnt"}, int'(err_cnt), 0);
      check({tag, "_fail_idx"}, int'(fail_idx), 0);
      check({tag, "_vec"}, int'(cur_vec), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_idle("reset");

      // clean sweep
      push_vecs(0, 31);
      push_res(0, 0, 1, 64);
      pulse_start();
      wait_done(80);

`ifdef SWEEP_STOP_ON_FAIL_EN
      // failures at 9 and 20: halt right after vector 9
      res_bad = 32'd0;
      res_bad[9] = 1'b1;
      res_bad[20] = 1'b1;
      push_vecs(0, 9);
      push_res(1, 9, 0, 20);
      pulse_start();
      wait_done(80);
      @(posedge clk); #1;
      check("stop_vec_held", int'(cur_vec), 9);
      check("stop_done_held", int'(done), 1);
      res_bad = 32'd0;
`else
      // single result fault at idx 5 (A=1,B=1,sel=0)
      res_bad = 32'd0;
      res_bad[5] = 1'b1;
      push_vecs(0, 31);
      push_res(1, 5, 0, 64);
      pulse_start();
      wait_done(80);

      // comparator reports mismatch everywhere: count reaches 32 without wrap
      res_bad = 32'd0;
      ok_bad = 1'b1;
      push_vecs(0, 31);
      push_res(32, 0, 0, 64);
      pulse_start();
      wait_done(80);
      ok_bad = 1'b0;

      // start during CHECK of idx 7 is ignored; fault at 5 leaves nonzero counters
      res_bad[5] = 1'b1;
      push_vecs(0, 31);
      push_res(1, 5, 0, 64);
      pulse_start();
      repeat (15) @(posedge clk);
      #1;
      check("ign_start_vec", int'(cur_vec), 7);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(80);

      // start in FINISH restarts with cleared counters
      res_bad = 32'd0;
      push_vecs(0, 31);
      push_res(0, 0, 1, 64);
      pulse_start();
      check("restart_done_drop", int'(done), 0);
      check("restart_busy", int'(busy), 1);
      check("restart_err_clr", int'(err_cnt), 0);
      check("restart_fidx_clr", int'(fail_idx), 0);
      wait_done(80);

      // reset during CHECK of idx 10 with two failures recorded; start in the reset cycle loses
      res_bad[3] = 1'b1;
      res_bad[6] = 1'b1;
      push_vecs(0, 10);
      pulse_start();
      repeat (21) @(posedge clk);
      #1;
      check("pre_rst_vec", int'(cur_vec), 10);
      check("pre_rst_err_cnt", int'(err_cnt), 2);
      check("pre_rst_fidx", int'(fail_idx), 3);
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      check_idle("midrst");
      @(posedge clk); #1;
      check("midrst_no_resume", int'(busy), 0);

      res_bad = 32'd0;
      push_vecs(0, 31);
      push_res(0, 0, 1, 64);
      pulse_start();
      wait_done(80);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("vec_q_drained", vec_q.size(), 0);
      check("res_q_drained", res_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/and_lut_sweep_checker.md
# and_lut_sweep_checker

Self-test sequencer that sits directly upstream of the AND gate/LUT comparison block. It drives that block's operand and select inputs and consumes its data and match outputs. On `start` it sweeps all 32 combinations of {sel, operand A, operand B} and checks each returned result against an internally computed A & B and against the comparator's match code. It then reports completion, pass/fail, an error count and the first failing vector.

## Interface
Parameters:
- `MATCH_CODE`, default 2'b01: comparator output value that means "gate result equals LUT result".

Ports:
- `clk`  input  1  single clock; all state changes on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  begin a sweep; sampled only in IDLE or FINISH
- `op_a`  output  2  operand A to the AND block; equals idx[3:2]
- `op_b`  output  2  operand B to the AND block; equals idx[1:0]
- `sel`  output  1  mux select to the AND block; equals idx[4]
- `res`  input  2  AND block data output (mux output)
- `ok`  input  2  AND block comparator output
- `busy`  output  1  high in APPLY and CHECK
- `done`  output  1  high in FINISH; held until the next accepted start
- `pass`  output  1  `done` & (`err_cnt` == 0)
- `err_cnt`  output  6  number of failing vectors, 0..32
- `fail_idx`  output  5  index of the first failing vector; valid when `err_cnt` != 0

## Operation
- 5-bit register `idx` drives `op_a`, `op_b` and `sel` combinationally. The outputs are stable for the whole APPLY/CHECK pair.
- Expected result: `exp` = `op_a` & `op_b`, computed bitwise, 2 bits wide.
- A vector fails if `res` != `exp` OR `ok` != `MATCH_CODE`. Each vector counts at most once.
- FSM states:
  - IDLE: on `start`, clear `idx`, `err_cnt` and `fail_idx`, then go to APPLY.
  - APPLY: settle cycle with no sampling; go to CHECK.
  - CHECK: sample `res` and `ok`.
    - On fail: `err_cnt` += 1. If `err_cnt` was 0, `fail_idx` <= `idx`.
    - If `idx` == 31, go to FINISH. Otherwise `idx` += 1 and go to APPLY.
  - FINISH: on `start`, perform the same clears as in IDLE and go to APPLY.
- `start` is ignored in APPLY and CHECK.
- `err_cnt` never wraps; its maximum is 32.
- `idx` is not incremented on the final vector. It stays at 31 through FINISH, so the last vector remains applied.

## Timing
- Reset: state = IDLE, `idx` = 0 (so `op_a` = 0, `op_b` = 0, `sel` = 0), `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `fail_idx` = 0.
- Each vector takes 2 cycles: APPLY then CHECK.
- Let edge E0 be the edge that accepts `start`. `busy` rises after E0, and `done` rises after edge E0+64.
- The CHECK for vector n falls in the cycle after edge E0+2n+1.
- `rst` asserted at any time, including mid-sweep, returns all state to reset values on that edge. The sweep is not resumed.
- `start` and `rst` in the same cycle: `rst` wins.
- `start` in FINISH: `done` drops after the accepting edge.

## Configuration
- Macro `SWEEP_STOP_ON_FAIL_EN`:
  - Defined: the first failing CHECK goes directly to FINISH. `err_cnt` = 1, `fail_idx` = failing index, and `idx` holds that index.
  - Undefined: the sweep always covers all 32 vectors and `err_cnt` reports the total number of failures.

## Test plan
- Correct AND block model, pulse `start` -> `done` rises 64 cycles after the accepting edge, `pass` = 1, `err_cnt` = 0, all 32 {sel,A,B} values driven exactly once in ascending order.
- Model forces `res` = 2'b11 only at idx 5 (A=1, B=1, sel=0) -> `err_cnt` = 1, `fail_idx` = 5, `pass` = 0.
- Model forces `ok` = 2'b00 on every vector -> `err_cnt` = 32, `fail_idx` = 0, no counter wrap.
- `start` pulsed at idx 7 during CHECK -> ignored; sweep completes at the original time. `start` pulsed in FINISH -> new sweep, counters cleared.
- `rst` asserted at idx 10 with `err_cnt` = 2 -> next cycle IDLE with all outputs 0. A following `start` yields a clean full sweep.
- With `SWEEP_STOP_ON_FAIL_EN`, failures at idx 9 and 20 -> FINISH entered right after the idx 9 CHECK, `err_cnt` = 1, `fail_idx` = 9, `op_a`/`op_b`/`sel` still reflect idx 9.
